instr_encoder: RTL and testbench

- Inverse of the main decoder: packs an instruction class plus register, funct and immediate fields into a legal 32-bit RV32I instruction word.
- Used by the self-test program generator and the boot/stimulus loader to feed the fetch path, so decoded controls can be cross-checked against the intended class.
- Valid/ready request input; a 2-entry output buffer decouples it from a stalling consumer.

---
 rtl/instr_encoder.sv | 166 ++++++++++++++++
 tb/tb_instr_encoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs an instruction class plus register/funct/immediate fields into a
//   legal RV32I instruction word and queues it in a 2-entry output buffer.
//
//   Build option: define INSTR_ENC_RANGE_CHECK_EN to flag immediates that do
//   not fit their format. Without it they are silently truncated.
//
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     req_valid_i/req_ready_o/req_*_i, rd_i, rs1_i, rs2_i, funct3_i,
//     funct7_i, imm_i   request side (fields qualify req_valid_i)
//     instr_valid_o/instr_ready_i/instr_o/instr_err_o  output word side
//     count_o           number of accepted requests (wraps)
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. The producer holds its payload stable while valid is high and
//   ready is low; ready never depends combinationally on valid.
module instr_encoder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [3:0]           req_class_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    input  logic [31:0]          imm_i,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,
    output logic [31:0]          instr_o,
    output logic                 instr_err_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic        is_shift;
    logic [31:0] enc_word;
    logic        enc_err;
    logic        range_err;

    // Shift-immediate forms carry funct7 in the upper immediate bits.
    assign is_shift = (req_class_i == 4'd1) &&
                      ((funct3_i == 3'b001) || (funct3_i == 3'b101));

    always_comb begin
        enc_word = 32'h0;
        enc_err  = 1'b0;
        case (req_class_i)
            4'd0: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
            4'd1: begin
                if (is_shift)
                    enc_word = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_I_ALU};
                else
                    enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I_ALU};
            end
            4'd2: enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
            4'd3: enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_S};
            4'd4: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], OP_B};
                enc_err  = imm_i[0];
            end
            4'd5: begin
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
                enc_err  = imm_i[0];
            end
            // JALR has a single legal funct3.
            4'd6: enc_word = {imm_i[11:0], rs1_i, 3'b000, rd_i, OP_JALR};
            4'd7: enc_word = {imm_i[31:12], rd_i, OP_LUI};
            4'd8: enc_word = {imm_i[31:12], rd_i, OP_AUIPC};
            default: begin
                enc_word = 32'h0;
                enc_err  = 1'b1;
            end
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    always_comb begin
        range_err = 1'b0;
        case (req_class_i)
            4'd1: begin
                if (is_shift)
                    range_err = (imm_i[31:5] != 27'h0);
                else
                    range_err = (imm_i != {{20{imm_i[11]}}, imm_i[11:0]});
            end
            4'd2, 4'd3, 4'd6: range_err = (imm_i != {{20{imm_i[11]}}, imm_i[11:0]});
            4'd4:             range_err = (imm_i != {{19{imm_i[12]}}, imm_i[12:0]});
            4'd5:             range_err = (imm_i != {{11{imm_i[20]}}, imm_i[20:0]});
            4'd7, 4'd8:       range_err = (imm_i[11:0] != 12'h0);
            default:          range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    // Output buffer: two {err, instr} entries in FIFO order.
    logic [32:0]          mem_q [2];
    logic [32:0]          mem_d [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           occ_q, occ_d;
    logic                 ready_q, ready_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 push, pop;

    assign push = req_valid_i & ready_q;
    assign pop  = (occ_q != 2'd0) & instr_ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        occ_d    = occ_q;
        count_d  = count_q + CNT_WIDTH'(push);
        if (push)
            mem_d[wr_ptr_q] = {enc_err | range_err, enc_word};
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        // Registered ready: a full buffer never accepts, even while popping.
        ready_d = (occ_d != 2'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= 33'h0;
            mem_q[1] <= 33'h0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            ready_q  <= 1'b1;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ready_q  <= ready_d;
            count_q  <= count_d;
        end
    end

    assign req_ready_o                = ready_q;
    assign instr_valid_o              = (occ_q != 2'd0);
    assign {instr_err_o, instr_o}     = mem_q[rd_ptr_q];
    assign count_o                    = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_class_i = 4'd0;
    logic [4:0]  rd_i = 5'd0, rs1_i = 5'd0, rs2_i = 5'd0;
    logic [2:0]  funct3_i = 3'd0;
    logic [6:0]  funct7_i = 7'd0;
    logic [31:0] imm_i = 32'd0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic        instr_err_o;
    logic [15:0] count_o;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    instr_encoder #(.CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_class_i(req_class_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .instr_err_o(instr_err_o), .count_o(count_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters / check ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        logic [31:0] mask;
        mask = (32'd1 << (hi - lo + 1)) - 32'd1;
        return (v >> lo) & mask;
    endfunction

    function automatic bit fits(input logic [31:0] v, input int n);
        int s;
        s = int'(v);
        return (s >= -(1 << (n - 1))) && (s < (1 << (n - 1)));
    endfunction

    // Returns {err, word}.
    function automatic logic [32:0] model(input logic [3:0] cls, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] imm);
        logic [6:0]  opc [9];
        logic [31:0] w, op, rdv, r1, r2, f3v, f7v;
        bit e, ok, shift;
        opc = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        rdv = 32'(rd) << 7;
        r1  = 32'(rs1) << 15;
        r2  = 32'(rs2) << 20;
        f3v = 32'(f3) << 12;
        f7v = 32'(f7) << 25;
        w = 32'd0; e = 1'b0; ok = 1'b1;
        if (cls > 4'd8) begin
            e = 1'b1;
        end else begin
            op = 32'(opc[int'(cls)]);
            shift = (cls == 4'd1) && (f3 == 3'd1 || f3 == 3'd5);
            case (cls)
                4'd0: w = f7v | r2 | r1 | f3v | rdv | op;
                4'd1, 4'd2: begin
                    if (shift) begin
                        w  = f7v | (fld(imm, 4, 0) << 20) | r1 | f3v | rdv | op;
                        ok = (imm < 32'd32);
                    end else begin
                        w  = (fld(imm, 11, 0) << 20) | r1 | f3v | rdv | op;
                        ok = fits(imm, 12);
                    end
                end
                4'd3: begin
                    w  = (fld(imm, 11, 5) << 25) | r2 | r1 | f3v | (fld(imm, 4, 0) << 7) | op;
                    ok = fits(imm, 12);
                end
                4'd4: begin
                    w  = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | r2 | r1 | f3v |
                         (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | op;
                    e  = (imm % 2) != 0;
                    ok = fits(imm, 13);
                end
                4'd5: begin
                    w  = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) |
                         (fld(imm, 11, 11) << 20) | (fld(imm, 19, 12) << 12) | rdv | op;
                    e  = (imm % 2) != 0;
                    ok = fits(imm, 21);
                end
                4'd6: begin
                    w  = (fld(imm, 11, 0) << 20) | r1 | rdv | op;
                    ok = fits(imm, 12);
                end
                default: begin
                    w  = (imm & 32'hFFFF_F000) | rdv | op;
                    ok = (imm % 4096) == 0;
                end
            endcase
            if (RANGE_EN && !ok) e = 1'b1;
        end
        return {e, w};
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    logic [15:0] exp_count = 16'd0;

    always @(negedge clk) begin
        if (!reset) begin
            check("valid", 64'(instr_valid_o), 64'(exp_q.size() != 0));
            check("req_ready", 64'(req_ready_o), 64'(exp_q.size() < 2));
            check("count", 64'(count_o), 64'(exp_count));
            if (instr_valid_o && exp_q.size() != 0) begin
                check("word", 64'({instr_err_o, instr_o}), 64'(exp_q[0]));
                if (instr_ready_i) void'(exp_q.pop_front());
            end
            if (req_valid_i && req_ready_o) begin
                exp_q.push_back(model(req_class_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i));
                exp_count++;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic set_req(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm);
        req_class_i = cls; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
        req_valid_i = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        logic acc;
        int n;
        set_req(cls, rd, rs1, rs2, f3, f7, imm);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = req_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        req_valid_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // model pins
        check("pin_i_alu", 64'(model(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5)), 64'h0_0050_0093);
        check("pin_jalr",  64'(model(4'd6, 5'd1, 5'd5, 5'd0, 3'd7, 7'd0, 32'h10)), 64'h0_0102_80E7);
        check("pin_b",     64'(model(4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC)), 64'h0_FE00_0EE3);

        cycles(2);
        reset = 1'b0;
        check("rst_valid", 64'(instr_valid_o), 64'd0);
        check("rst_instr", 64'(instr_o), 64'd0);
        check("rst_err", 64'(instr_err_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd1);
        cycles(1);

        send(4'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
        check("i_alu_word", 64'(instr_o), 64'h0050_0093);
        check("i_alu_err", 64'(instr_err_o), 64'd0);
        check("i_alu_count", 64'(count_o), 64'd1);

        send(4'd3, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
        check("s_word", 64'(instr_o), 64'h0020_A423);

        send(4'd4, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFC);
        check("b_word", 64'(instr_o), 64'hFE00_0EE3);
        send(4'd5, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8);
        check("jal_word", 64'(instr_o), 64'h0080_00EF);
        send(4'd5, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd9);
        check("jal_odd_word", 64'(instr_o), 64'h0080_00EF);
        check("jal_odd_err", 64'(instr_err_o), 64'd1);

        send(4'd7, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000);
        check("lui_word", 64'(instr_o), 64'h1234_52B7);
        send(4'd12, 5'd5, 5'd3, 5'd4, 3'b111, 7'h7F, 32'hFFFF_FFFF);
        check("illegal_word", 64'(instr_o), 64'h0);
        check("illegal_err", 64'(instr_err_o), 64'd1);
        check("count_7", 64'(count_o), 64'd7);

        // back-to-back stream, model-checked
        send(4'd1, 5'd4, 5'd3, 5'd0, 3'b001, 7'h00, 32'd3);
        send(4'd1, 5'd4, 5'd3, 5'd0, 3'b101, 7'h20, 32'd4);
        send(4'd6, 5'd1, 5'd5, 5'd0, 3'b111, 7'd0, 32'h10);
        send(4'd8, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'hABCD_E000);
        send(4'd1, 5'd6, 5'd7, 5'd0, 3'b000, 7'd0, 32'h800);
        send(4'd3, 5'd0, 5'd8, 5'd9, 3'b000, 7'd0, 32'h1000);
        send(4'd4, 5'd0, 5'd1, 5'd2, 3'b001, 7'd0, 32'h2000);
        send(4'd0, 5'd5, 5'd6, 5'd7, 3'b000, 7'h20, 32'd0);
        cycles(3);

        // backpressure
        instr_ready_i = 1'b0;
        send(4'd2, 5'd3, 5'd2, 5'd0, 3'b010, 7'd0, 32'hFFFF_FFFC);
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
        check("bp_ready_drop", 64'(req_ready_o), 64'd0);
        set_req(4'd0, 5'd5, 5'd6, 5'd7, 3'b000, 7'h20, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            check("bp_hold_ready", 64'(req_ready_o), 64'd0);
            check("bp_hold_word", 64'(instr_o), 64'hFFC1_2183);
            check("bp_hold_count", 64'(count_o), 64'd17);
        end
        instr_ready_i = 1'b1;
        cycles(1);
        check("bp_second_word", 64'(instr_o), 64'h0020_81B3);
        check("bp_ready_back", 64'(req_ready_o), 64'd1);
        check("bp_third_held", 64'(count_o), 64'd17);
        cycles(1);
        req_valid_i = 1'b0;
        check("bp_third_acc", 64'(count_o), 64'd18);
        check("bp_third_word", 64'(instr_o), 64'h4073_02B3);
        cycles(3);

        // reset with two words buffered
        instr_ready_i = 1'b0;
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
        send(4'd3, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_count = 16'd0;
        #1;
        check("mid_rst_valid", 64'(instr_valid_o), 64'd0);
        check("mid_rst_count", 64'(count_o), 64'd0);
        check("mid_rst_instr", 64'(instr_o), 64'd0);
        check("mid_rst_ready", 64'(req_ready_o), 64'd1);
        cycles(2);
        reset = 1'b0;
        instr_ready_i = 1'b1;
        cycles(1);

        // I_ALU immediate one past the 12-bit signed range
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h800);
        check("range_err", 64'(instr_err_o), 64'(RANGE_EN));
        check("range_word", 64'(instr_o), 64'h8000_0093);
        cycles(3);
        check("final_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
